// File: rtl/decode_ctrl_stage.sv
// ID/EX control stage: decodes opcode (and funct7 for RV32M) into the control
// bundle, registers it with valid/ready handshake, stall/flush and MDU hold.
module decode_ctrl_stage #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic        regwrite,
  output logic [2:0]  immsrc,
  output logic        alusrc,
  output logic        memwrite,
  output logic [2:0]  resultsrc,
  output logic        branch,
  output logic [1:0]  aluop,
  output logic        jump,
  output logic        jalr,
  output logic        mdu_op,
  output logic        illegal
);

  typedef struct packed {
    logic       regwrite;
    logic [2:0] immsrc;
    logic       alusrc;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic       branch;
    logic [1:0] aluop;
    logic       jump;
    logic       jalr;
  } ctrl_t;

  typedef enum logic {RUN, MDU_HOLD} state_t;

  localparam bit               HOLD_EN   = (MDU_LATENCY > 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept;

  ctrl_t dec;
  logic  dec_mdu;
  logic  dec_ill;

  ctrl_t ctrl_q;
  logic  valid_q;
  logic  mdu_q;
  logic  ill_q;

  always_comb begin
    dec     = '0;
    dec_mdu = 1'b0;
    dec_ill = 1'b0;
    case (instr[6:0])
      7'b0000011: dec = 14'b1_000_1_0_001_0_00_0_0;
      7'b0100011: dec = 14'b0_001_1_1_000_0_00_0_0;
      7'b0110011: begin
        dec = 14'b1_000_0_0_000_0_10_0_0;
        if (ENABLE_M && (instr[31:25] == 7'b0000001)) begin
          dec.aluop = 2'b11;
          dec_mdu   = 1'b1;
        end
      end
      7'b1100011: dec = 14'b0_010_0_0_000_1_01_0_0;
      7'b0010011: dec = 14'b1_000_1_0_000_0_10_0_0;
      7'b1101111: dec = 14'b1_011_0_0_010_0_00_1_0;
      7'b1100111: dec = 14'b1_000_1_0_010_0_00_0_1;
      7'b0110111: dec = 14'b1_100_0_0_011_0_00_0_0;
      7'b0010111: dec = 14'b1_100_0_0_100_0_00_0_0;
      default:    dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Leaving HOLD when cnt==1 lets the next instr land MDU_LATENCY edges after the M-op.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = RUN;
      cnt_nx   = '0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (accept && dec_mdu && HOLD_EN) begin
            state_nx = MDU_HOLD;
            cnt_nx   = HOLD_INIT;
          end
        end
        MDU_HOLD: begin
          cnt_nx = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready = rst_n && !stall && (state == RUN);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      mdu_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      mdu_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        valid_q <= 1'b1;
        ctrl_q  <= dec;
        mdu_q   <= dec_mdu;
        ill_q   <= dec_ill;
      end else begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        mdu_q   <= 1'b0;
        ill_q   <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign regwrite  = ctrl_q.regwrite;
  assign immsrc    = ctrl_q.immsrc;
  assign alusrc    = ctrl_q.alusrc;
  assign memwrite  = ctrl_q.memwrite;
  assign resultsrc = ctrl_q.resultsrc;
  assign branch    = ctrl_q.branch;
  assign aluop     = ctrl_q.aluop;
  assign jump      = ctrl_q.jump;
  assign jalr      = ctrl_q.jalr;
  assign mdu_op    = mdu_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: decode table, illegal, MDU hold,
// stall, flush and asynchronous reset, with an ENABLE_M=0 companion instance.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        flush;

  logic        in_ready, out_valid, regwrite, alusrc, memwrite, branch, jump, jalr, mdu_op, illegal;
  logic [2:0]  immsrc, resultsrc;
  logic [1:0]  aluop;

  logic        n_in_ready, n_out_valid, n_regwrite, n_alusrc, n_memwrite, n_branch, n_jump, n_jalr, n_mdu_op, n_illegal;
  logic [2:0]  n_immsrc, n_resultsrc;
  logic [1:0]  n_aluop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.ENABLE_M(1'b1), .MDU_LATENCY(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(out_valid), .regwrite(regwrite), .immsrc(immsrc),
    .alusrc(alusrc), .memwrite(memwrite), .resultsrc(resultsrc), .branch(branch), .aluop(aluop),
    .jump(jump), .jalr(jalr), .mdu_op(mdu_op), .illegal(illegal)
  );

  decode_ctrl_stage #(.ENABLE_M(1'b0), .MDU_LATENCY(4), .CNT_W(3)) dut_nom (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(n_out_valid), .regwrite(n_regwrite), .immsrc(n_immsrc),
    .alusrc(n_alusrc), .memwrite(n_memwrite), .resultsrc(n_resultsrc), .branch(n_branch), .aluop(n_aluop),
    .jump(n_jump), .jalr(n_jalr), .mdu_op(n_mdu_op), .illegal(n_illegal)
  );

  wire [13:0] bundle   = {regwrite, immsrc, alusrc, memwrite, resultsrc, branch, aluop, jump, jalr};
  wire [13:0] n_bundle = {n_regwrite, n_immsrc, n_alusrc, n_memwrite, n_resultsrc, n_branch, n_aluop, n_jump, n_jalr};

  localparam logic [13:0] B_LOAD  = 14'b1_000_1_0_001_0_00_0_0;
  localparam logic [13:0] B_STORE = 14'b0_001_1_1_000_0_00_0_0;
  localparam logic [13:0] B_R     = 14'b1_000_0_0_000_0_10_0_0;
  localparam logic [13:0] B_BR    = 14'b0_010_0_0_000_1_01_0_0;
  localparam logic [13:0] B_I     = 14'b1_000_1_0_000_0_10_0_0;
  localparam logic [13:0] B_JAL   = 14'b1_011_0_0_010_0_00_1_0;
  localparam logic [13:0] B_JALR  = 14'b1_000_1_0_010_0_00_0_1;
  localparam logic [13:0] B_LUI   = 14'b1_100_0_0_011_0_00_0_0;
  localparam logic [13:0] B_AUIPC = 14'b1_100_0_0_100_0_00_0_0;
  localparam logic [13:0] B_MUL   = 14'b1_000_0_0_000_0_11_0_0;

  localparam logic [31:0] I_LW  = 32'h0000_0003;
  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_MUL = 32'h0200_0033;
  localparam logic [31:0] I_BAD = 32'h0000_007F;

  logic [6:0]  ops  [9];
  logic [13:0] exps [9];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ops[0] = 7'b0000011; exps[0] = B_LOAD;
    ops[1] = 7'b0100011; exps[1] = B_STORE;
    ops[2] = 7'b0110011; exps[2] = B_R;
    ops[3] = 7'b1100011; exps[3] = B_BR;
    ops[4] = 7'b0010011; exps[4] = B_I;
    ops[5] = 7'b1101111; exps[5] = B_JAL;
    ops[6] = 7'b1100111; exps[6] = B_JALR;
    ops[7] = 7'b0110111; exps[7] = B_LUI;
    ops[8] = 7'b0010111; exps[8] = B_AUIPC;

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
    #2;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("post_rst_bundle", 32'(bundle), 32'd0);

    // decode sweep, back-to-back
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      instr    = {25'd0, ops[i]};
      tick();
      check_val($sformatf("dec%0d_valid", i), 32'(out_valid), 32'd1);
      check_val($sformatf("dec%0d_illegal", i), 32'(illegal), 32'd0);
      check_val($sformatf("dec%0d_bundle", i), 32'(bundle), 32'(exps[i]));
    end
    in_valid = 1'b0;
    tick();
    check_val("drain_valid", 32'(out_valid), 32'd0);
    check_val("drain_bundle", 32'(bundle), 32'd0);

    // illegal opcode
    in_valid = 1'b1; instr = I_BAD;
    tick();
    check_val("ill_valid", 32'(out_valid), 32'd1);
    check_val("ill_flag", 32'(illegal), 32'd1);
    check_val("ill_bundle", 32'(bundle), 32'd0);
    check_val("ill_mdu", 32'(mdu_op), 32'd0);
    in_valid = 1'b0;
    tick();
    check_val("ill_one_cycle", 32'(illegal), 32'd0);

    // MDU hold: MUL then ADD held on the input
    in_valid = 1'b1; instr = I_MUL;
    tick();
    check_val("mul_valid", 32'(out_valid), 32'd1);
    check_val("mul_bundle", 32'(bundle), 32'(B_MUL));
    check_val("mul_mdu_op", 32'(mdu_op), 32'd1);
    check_val("nom_mul_bundle", 32'(n_bundle), 32'(B_R));
    check_val("nom_mul_mdu_op", 32'(n_mdu_op), 32'd0);
    instr = I_ADD;
    #1;
    check_val("nom_in_ready", 32'(n_in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
      check_val($sformatf("hold%0d_bubble", k), 32'(out_valid), 32'd0);
    end
    check_val("hold_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("add_after_mul_valid", 32'(out_valid), 32'd1);
    check_val("add_after_mul_bundle", 32'(bundle), 32'(B_R));
    check_val("add_after_mul_mdu", 32'(mdu_op), 32'd0);
    in_valid = 1'b0;
    tick();

    // stall holds a lw bundle and does not consume the input
    in_valid = 1'b1; instr = I_LW;
    tick();
    check_val("lw_bundle", 32'(bundle), 32'(B_LOAD));
    stall = 1'b1; instr = I_ADD;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
      check_val($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      check_val($sformatf("stall%0d_bundle", k), 32'(bundle), 32'(B_LOAD));
    end
    stall = 1'b0;
    tick();
    check_val("post_stall_bundle", 32'(bundle), 32'(B_R));
    in_valid = 1'b0;
    tick();
    check_val("post_stall_drain", 32'(out_valid), 32'd0);

    // flush with stall during MDU hold
    in_valid = 1'b1; instr = I_MUL;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("flush_pre_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; instr = I_ADD;
    tick();
    check_val("flush_valid", 32'(out_valid), 32'd0);
    check_val("flush_bundle", 32'(bundle), 32'd0);
    check_val("flush_mdu", 32'(mdu_op), 32'd0);
    flush = 1'b0; stall = 1'b0;
    #1;
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("flush_next_valid", 32'(out_valid), 32'd1);
    check_val("flush_next_bundle", 32'(bundle), 32'(B_R));

    // asynchronous reset mid-hold
    instr = I_MUL;
    tick();
    check_val("rst2_mul_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst2_valid", 32'(out_valid), 32'd0);
    check_val("rst2_bundle", 32'(bundle), 32'd0);
    check_val("rst2_mdu", 32'(mdu_op), 32'd0);
    check_val("rst2_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_val("rst2_rel_in_ready", 32'(in_ready), 32'd1);
    check_val("rst2_rel_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; instr = I_LW;
    tick();
    check_val("rst2_lw_bundle", 32'(bundle), 32'(B_LOAD));
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
